// File: rtl/apb_arb_pkg.sv
// Shared types and default sizing for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
module apb_rr_pick
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      winner,
    output logic               found
);

    logic [IW-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = last_grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters onto a single APB master,
// with a bounded wait for the master's ready and a timeout error flag.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ-1:0][31:0]   req_addr,
    input  logic [NUM_REQ-1:0][31:0]   req_wdata,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [31:0]                req_rdata,
    output logic                       req_err,
    output logic                       transfer,
    output logic                       write,
    output logic [31:0]                addr,
    output logic [31:0]                wdata,
    input  logic                       ready,
    input  logic [31:0]                rdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    arb_state_t    state;
    logic [IW-1:0] last_grant;
    logic [CW-1:0] count;
    logic [IW-1:0] winner;
    logic          found;

    apb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .found      (found)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            transfer   <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            req_done   <= '0;
            req_rdata  <= '0;
            req_err    <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= '0;
            count      <= '0;
            last_grant <= IW'(NUM_REQ - 1);
        end else begin
            transfer <= 1'b0;
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= winner;
                        write    <= req_write[winner];
                        addr     <= req_addr[winner];
                        wdata    <= req_wdata[winner];
                        transfer <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    count <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // ready takes priority over an expiring timeout on the same cycle
                    if (ready) begin
                        req_rdata          <= rdata;
                        req_err            <= 1'b0;
                        req_done[grant_id] <= 1'b1;
                        state              <= DONE;
                    end else if (count == CW'(TIMEOUT - 1)) begin
                        req_rdata          <= '0;
                        req_err            <= 1'b1;
                        req_done[grant_id] <= 1'b1;
                        state              <= DONE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomised self-checking bench for apb_req_arbiter against a transaction-level
// round-robin model with a simple APB master responder.
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int IW = $clog2(N);

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [N-1:0][31:0] req_addr;
    logic [N-1:0][31:0] req_wdata;
    logic [N-1:0]      req_done;
    logic [31:0]       req_rdata;
    logic              req_err;
    logic              transfer;
    logic              write;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              ready;
    logic [31:0]       rdata;
    logic [IW-1:0]     grant_id;
    logic              busy;

    int           n_checks = 0;
    int           n_errors = 0;
    int           m_last;
    logic [N-1:0] hold;
    int           waited [N];

    apb_req_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .transfer  (transfer),
        .write     (write),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Round-robin reference: first pending requester after the last one served.
    function automatic int rr_expect(input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (m_last + i) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic raise(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_valid[i] = 1'b1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_transfer"}, 32'(transfer), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_req_done"}, 32'(req_done), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
        check({tag, "_write"}, 32'(write), 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_req_err"}, 32'(req_err), 0);
        check({tag, "_req_rdata"}, req_rdata, 0);
    endtask

    task automatic do_reset();
        PRESET    = 1'b1;
        req_valid = '0;
        hold      = '0;
        ready     = 1'b0;
        tick();
        PRESET = 1'b0;
        m_last = N - 1;
    endtask

    // One full transaction: k = WAIT cycle index on which ready is raised
    // (k >= TO means the master never answers), rd = read data returned.
    task automatic run_txn(input int k, input logic [31:0] rd, input bit drop, output int gid);
        int          exp;
        bit          seen;
        bit          fin;
        logic        e_write;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        gid  = -1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (transfer) begin
                seen = 1'b1;
                break;
            end
        end
        check("xfer_seen", 32'(seen), 1);
        if (!seen) return;
        exp = rr_expect(req_valid);
        if (exp < 0) exp = 0;
        gid     = exp;
        e_write = req_write[exp];
        e_addr  = req_addr[exp];
        e_wdata = req_wdata[exp];
        check("grant_id", 32'(grant_id), 32'(exp));
        check("busy_issue", 32'(busy), 1);
        check("xfer_write", 32'(write), 32'(e_write));
        check("xfer_addr", addr, e_addr);
        check("xfer_wdata", wdata, e_wdata);
        ready = 1'($urandom_range(0, 1));
        rdata = $urandom;
        tick();
        check("xfer_pulse", 32'(transfer), 0);
        fin = 1'b0;
        for (int w = 0; w < TO && !fin; w++) begin
            if (w == 0 && drop) req_valid[exp] = 1'b0;
            ready = (w == k);
            rdata = (w == k) ? rd : $urandom;
            tick();
            if (w == k || w == TO - 1) fin = 1'b1;
            else check("early_done", 32'(req_done), 0);
        end
        check("done_onehot", 32'(req_done), 32'(1) << exp);
        check("req_err", 32'(req_err), (k < TO) ? 32'd0 : 32'd1);
        check("req_rdata", req_rdata, (k < TO) ? rd : 32'd0);
        check("addr_stable", addr, e_addr);
        check("wdata_stable", wdata, e_wdata);
        check("busy_done", 32'(busy), 1);
        ready = 1'($urandom_range(0, 1));
        rdata = $urandom;
        if (!hold[exp]) req_valid[exp] = 1'b0;
        m_last = exp;
        tick();
        check("idle_done_low", 32'(req_done), 0);
        check("busy_idle", 32'(busy), 0);
        ready = 1'b0;
    endtask

    initial begin
        int           g;
        int           k;
        bit           seen;
        logic [N-1:0] pend;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        ready     = 1'b0;
        rdata     = '0;
        hold      = '0;
        m_last    = N - 1;
        PRESET    = 1'b1;
        repeat (2) tick();
        check_reset_outs("rst");
        PRESET = 1'b0;

        // single write, ready two cycles after transfer
        raise(0, 1'b1, 32'h1000_0000, 32'h0000_000A);
        run_txn(1, 32'h0, 1'b0, g);
        check("single_gid", 32'(g), 0);

        // all four requesting after reset
        do_reset();
        for (int i = 0; i < N; i++) raise(i, 1'($urandom), $urandom, $urandom);
        for (int i = 0; i < N; i++) begin
            run_txn($urandom_range(0, 3), $urandom, 1'b0, g);
            check("rr_order", 32'(g), 32'(i));
        end

        // req1 held continuously against req2
        do_reset();
        hold = 4'b0110;
        raise(1, 1'b1, 32'h2000_0010, 32'h1111_1111);
        raise(2, 1'b0, 32'h2000_0020, 32'h2222_2222);
        for (int i = 0; i < 4; i++) begin
            run_txn(0, $urandom, 1'b0, g);
            check("fair_order", 32'(g), (i % 2 == 0) ? 32'd1 : 32'd2);
        end

        // read from requester 3
        do_reset();
        raise(3, 1'b0, 32'h1000_2000, 32'h0);
        run_txn(2, 32'h0000_000C, 1'b0, g);
        check("read_gid", 32'(g), 3);

        // timeout, then ready on the final permitted cycle
        raise(1, 1'b0, 32'h3000_0000, 32'h0);
        run_txn(TO + 3, 32'hDEAD_BEEF, 1'b0, g);
        raise(2, 1'b0, 32'h3000_0004, 32'h0);
        run_txn(TO - 1, 32'h5A5A_0001, 1'b0, g);

        // reset pulsed while waiting on ready
        do_reset();
        raise(0, 1'b1, 32'h4000_0000, 32'h0);
        run_txn(0, 32'h0, 1'b0, g);
        raise(0, 1'b1, 32'h4000_0100, 32'h0000_0077);
        raise(2, 1'b0, 32'h4000_0200, 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (transfer) begin
                seen = 1'b1;
                break;
            end
        end
        check("rw_xfer", 32'(seen), 1);
        check("rw_gid", 32'(grant_id), 2);
        ready = 1'b0;
        repeat (2) tick();
        #2 PRESET = 1'b1;
        #1 check_reset_outs("rst_wait");
        tick();
        check("rst_no_done", 32'(req_done), 0);
        PRESET = 1'b0;
        m_last = N - 1;
        run_txn(1, 32'h0000_1234, 1'b0, g);
        check("rw_first", 32'(g), 0);
        run_txn(0, 32'h0000_5678, 1'b0, g);
        check("rw_second", 32'(g), 2);

        // randomised traffic
        do_reset();
        for (int i = 0; i < N; i++) waited[i] = 0;
        repeat (60) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    raise(i, 1'($urandom), $urandom, $urandom);
            if (req_valid == '0)
                raise($urandom_range(0, N - 1), 1'($urandom), $urandom, $urandom);
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 4);
            pend = req_valid;
            run_txn(k, $urandom, ($urandom_range(0, 4) == 0), g);
            for (int i = 0; i < N; i++) begin
                if (i == g) begin
                    waited[i] = 0;
                end else if (pend[i]) begin
                    waited[i]++;
                    check("starvation", 32'(waited[i] <= N - 1), 1);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
